mul_wb_queue: RTL and testbench
===============================

Name: mul_wb_queue

Overview:
- Writeback merge stage directly downstream of the 4-stage pipelined multiplier.
- Multiplier results (mul_res/valid/rd, no backpressure) compete with the main in-order pipeline for the single register-file write port.
- The main pipe always wins. Multiplier results wait in a small FIFO and drain on idle pipe cycles.
- Provides RAW hazard flags for queued destinations and WAW squashing so a younger pipe write is never overwritten by an older queued mul result.

Parameters:
- DEPTH, 4, FIFO entries. Power of two, >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- mul_valid_i  in  1  multiplier result valid (one-cycle pulse)
- mul_rd_i  in  5  multiplier destination register
- mul_res_i  in  64  multiplier result
- pipe_wb_en_i  in  1  main pipe writes this cycle
- pipe_rd_i  in  5  main pipe destination
- pipe_data_i  in  64  main pipe write data
- rs1_addr_i  in  5  decode-stage source 1
- rs2_addr_i  in  5  decode-stage source 2
- rf_wr_en_o  out  1  register-file write enable (registered)
- rf_wr_addr_o  out  5  register-file write address (registered)
- rf_wr_data_o  out  64  register-file write data (registered)
- rs1_hazard_o  out  1  rs1 matches a pending mul destination (combinational)
- rs2_hazard_o  out  1  rs2 matches a pending mul destination (combinational)
- wbq_full_o  out  1  count == DEPTH (combinational from state)
- wbq_empty_o  out  1  count == 0
- overflow_o  out  1  sticky: a mul result was lost because the queue was full

Behaviour:
- Reset: all rf_wr_* outputs = 0, count = 0, read/write pointers = 0, all entry valid bits = 0, overflow_o = 0. wbq_empty_o = 1 and hazard flags = 0 after reset.
- Reset mid-operation discards all queued entries; no write is issued the following cycle.
- Storage: circular FIFO of {valid, rd[4:0], data[63:0]}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Write-port selection each cycle, in priority order. The result is registered into rf_wr_*_o, so there is 1-cycle latency from selection to write:
  1. pipe_wb_en_i=1: write pipe_rd_i/pipe_data_i.
  2. Else, queue head valid: pop head and write it.
  3. Else, head squashed (valid=0): pop it with no write (rf_wr_en_o=0).
  4. Else, queue empty and mul_valid_i=1 with mul_rd_i!=0 and not squashed: bypass directly to the write port, no enqueue.
  5. Else: rf_wr_en_o=0.
- Enqueue: mul_valid_i=1, mul_rd_i!=0, and not bypassed.
  - Pushes only if count < DEPTH, or if a pop occurs in the same cycle (simultaneous push+pop at full is allowed).
  - Otherwise the result is dropped and overflow_o is set. overflow_o clears only on reset.
- x0: a mul result with mul_rd_i==0 is never enqueued or written. A pipe write to x0 is passed through unchanged; the register file ignores it.
- WAW squash: when pipe_wb_en_i=1 and pipe_rd_i!=0, every queued entry with rd==pipe_rd_i has its valid cleared in the same cycle. The entry still occupies its slot until popped.
- Same-cycle ordering: if mul_valid_i and pipe_wb_en_i target the same nonzero rd, the pipe instruction is younger. The mul result is dropped, not counted as overflow.
- Hazards: rsN_hazard_o=1 iff rsN_addr_i!=0 and either:
  - any entry has valid=1 and rd==rsN_addr_i, or
  - mul_valid_i=1 and mul_rd_i==rsN_addr_i.
- Hazard flags are combinational, for decode to stall on.
- The block never forwards data; consumers wait for the write.

Test Plan:
- Bypass: queue empty, pipe idle. mul_valid_i=1, rd=5, res=0x1234 -> next cycle rf_wr_en_o=1, addr=5, data=0x1234; wbq_empty_o stays 1.
- Contention: pipe writes rd=3 on 3 consecutive cycles; mul rd=7, res=0xAA arrives in the first of them -> three pipe writes, then rd=7/0xAA on cycle 4; rs1_addr_i=7 raises rs1_hazard_o until the pop cycle.
- Fill/overflow with DEPTH=4: pipe busy continuously, 5 mul results rd=1..5 -> wbq_full_o after the 4th, overflow_o=1 after the 5th; release the pipe -> rd 1,2,3,4 written in order, rd 5 never written.
- Push+pop at full: queue full, pipe idle, mul rd=9 arrives -> head popped and rd=9 enqueued same cycle; count stays 4; overflow_o=0.
- WAW: queue holds rd=10 (data 0x55) while the pipe writes rd=10 data 0x66 -> only 0x66 is written; the squashed entry pops with rf_wr_en_o=0.
- Reset mid-operation with 3 entries queued -> the next cycle has rf_wr_en_o=0, wbq_empty_o=1, hazards=0, overflow_o=0.

Source files
------------

// File: rtl/mul_wb_queue.sv
// mul_wb_queue: writeback merge stage behind the pipelined multiplier.
//
// The main in-order pipe owns the single register-file write port whenever
// it writes. Multiplier results arrive with no backpressure: the multiplier
// never waits. A result that cannot be written at once is parked in a small
// circular FIFO and drained on idle pipe cycles. A result that finds the
// FIFO full with no pop that cycle is lost, and the sticky overflow flag is
// set. There is no valid/ready handshake here, only single-cycle valid
// pulses on each source.
//
// Pending destinations raise combinational RAW hazard flags so that decode
// can stall. A pipe write squashes older queued results for the same rd so
// they can never overwrite the younger value.

module mul_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mul_valid_i,
    input  logic [4:0]  mul_rd_i,
    input  logic [63:0] mul_res_i,
    input  logic        pipe_wb_en_i,
    input  logic [4:0]  pipe_rd_i,
    input  logic [63:0] pipe_data_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic        rf_wr_en_o,
    output logic [4:0]  rf_wr_addr_o,
    output logic [63:0] rf_wr_data_o,
    output logic        rs1_hazard_o,
    output logic        rs2_hazard_o,
    output logic        wbq_full_o,
    output logic        wbq_empty_o,
    output logic        overflow_o
);

    localparam int              PW         = $clog2(DEPTH);
    localparam logic [PW:0]     FULL_COUNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0]     COUNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0]   PTR_ONE    = PW'(1);

    // FIFO storage: one {valid, rd, data} entry per slot
    logic        ent_valid [DEPTH];
    logic [4:0]  ent_rd    [DEPTH];
    logic [63:0] ent_data  [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          overflow_q;

    // Per-cycle decisions
    logic        head_valid;
    logic        queue_empty;
    logic        queue_full;
    logic        mul_live;
    logic        pipe_kills_mul;
    logic        pipe_squash;
    logic        pop;
    logic        bypass;
    logic        push_req;
    logic        push;
    logic        drop;
    logic        sel_en;
    logic [4:0]  sel_addr;
    logic [63:0] sel_data;

    // Hazard match terms
    logic rs1_match;
    logic rs2_match;

    // Write-port arbitration, push/pop and drop decisions for this cycle
    always_comb begin
        head_valid     = ent_valid[rd_ptr];
        queue_empty    = (count == '0);
        queue_full     = (count == FULL_COUNT);
        mul_live       = mul_valid_i && (mul_rd_i != 5'd0);
        pipe_squash    = pipe_wb_en_i && (pipe_rd_i != 5'd0);
        // The pipe instruction is younger: a mul result for the same rd is
        // dead on arrival and is discarded without counting as overflow.
        pipe_kills_mul = pipe_squash && (pipe_rd_i == mul_rd_i);
        // A pop happens on every idle pipe cycle with something queued,
        // whether the head is still live or has been squashed.
        pop            = !pipe_wb_en_i && !queue_empty;
        bypass         = !pipe_wb_en_i && queue_empty && mul_live;
        push_req       = mul_live && !bypass && !pipe_kills_mul;
        push           = push_req && (!queue_full || pop);
        drop           = push_req && !push;

        sel_en   = 1'b0;
        sel_addr = 5'd0;
        sel_data = 64'd0;
        if (pipe_wb_en_i) begin
            sel_en   = 1'b1;
            sel_addr = pipe_rd_i;
            sel_data = pipe_data_i;
        end else if (pop && head_valid) begin
            sel_en   = 1'b1;
            sel_addr = ent_rd[rd_ptr];
            sel_data = ent_data[rd_ptr];
        end else if (bypass) begin
            sel_en   = 1'b1;
            sel_addr = mul_rd_i;
            sel_data = mul_res_i;
        end
    end

    // RAW hazard flags against live queued entries and the incoming result
    always_comb begin
        rs1_match = 1'b0;
        rs2_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] == rs1_addr_i)) begin
                rs1_match = 1'b1;
            end
            if (ent_valid[i] && (ent_rd[i] == rs2_addr_i)) begin
                rs2_match = 1'b1;
            end
        end
        if (mul_valid_i && (mul_rd_i == rs1_addr_i)) begin
            rs1_match = 1'b1;
        end
        if (mul_valid_i && (mul_rd_i == rs2_addr_i)) begin
            rs2_match = 1'b1;
        end
        rs1_hazard_o = (rs1_addr_i != 5'd0) && rs1_match;
        rs2_hazard_o = (rs2_addr_i != 5'd0) && rs2_match;
    end

    // Status flags derived from the stored count
    always_comb begin
        wbq_full_o  = queue_full;
        wbq_empty_o = queue_empty;
        overflow_o  = overflow_q;
    end

    // Entry storage: squash on pipe writes, retire on pop, fill on push
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid[i] <= 1'b0;
                ent_rd[i]    <= 5'd0;
                ent_data[i]  <= 64'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_squash && (ent_rd[i] == pipe_rd_i)) begin
                    ent_valid[i] <= 1'b0;
                end
            end
            // Clearing on pop keeps stale slots out of the hazard match.
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
            end
            // At full, push+pop targets the slot being popped; the push wins.
            if (push) begin
                ent_valid[wr_ptr] <= 1'b1;
                ent_rd[wr_ptr]    <= mul_rd_i;
                ent_data[wr_ptr]  <= mul_res_i;
            end
        end
    end

    // Read/write pointers and occupancy count
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + COUNT_ONE;
            end else if (pop && !push) begin
                count <= count - COUNT_ONE;
            end
        end
    end

    // Sticky overflow: set when a result is lost, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    // Registered register-file write port
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_wr_en_o   <= 1'b0;
            rf_wr_addr_o <= 5'd0;
            rf_wr_data_o <= 64'd0;
        end else begin
            rf_wr_en_o   <= sel_en;
            rf_wr_addr_o <= sel_addr;
            rf_wr_data_o <= sel_data;
        end
    end

endmodule

// File: tb/tb_mul_wb_queue.sv
// tb_mul_wb_queue: directed scenarios followed by random traffic, all
// checked every cycle against a queue-based reference model.

module tb_mul_wb_queue;

    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        mul_valid_i;
    logic [4:0]  mul_rd_i;
    logic [63:0] mul_res_i;
    logic        pipe_wb_en_i;
    logic [4:0]  pipe_rd_i;
    logic [63:0] pipe_data_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        rf_wr_en_o;
    logic [4:0]  rf_wr_addr_o;
    logic [63:0] rf_wr_data_o;
    logic        rs1_hazard_o;
    logic        rs2_hazard_o;
    logic        wbq_full_o;
    logic        wbq_empty_o;
    logic        overflow_o;

    always #5 clk = ~clk;

    mul_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .mul_valid_i  (mul_valid_i),
        .mul_rd_i     (mul_rd_i),
        .mul_res_i    (mul_res_i),
        .pipe_wb_en_i (pipe_wb_en_i),
        .pipe_rd_i    (pipe_rd_i),
        .pipe_data_i  (pipe_data_i),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .rf_wr_en_o   (rf_wr_en_o),
        .rf_wr_addr_o (rf_wr_addr_o),
        .rf_wr_data_o (rf_wr_data_o),
        .rs1_hazard_o (rs1_hazard_o),
        .rs2_hazard_o (rs2_hazard_o),
        .wbq_full_o   (wbq_full_o),
        .wbq_empty_o  (wbq_empty_o),
        .overflow_o   (overflow_o)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v;
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t        mq[$];        // pending mul results, oldest first
    logic        m_ovf;
    logic [69:0] exp_q[$];     // expected {en, addr, data} of the write port

    int checks = 0;
    int errors = 0;

    function automatic logic m_hazard(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        if (mul_valid_i && mul_rd_i == rs) return 1'b1;
        foreach (mq[i]) begin
            if (mq[i].v && mq[i].rd == rs) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Apply one cycle of the writeback rules to the model state.
    function automatic void model_step();
        logic        en;
        logic [4:0]  a;
        logic [63:0] d;
        logic        mul_live;
        logic        consumed;
        ent_t        e;
        en = 1'b0; a = 5'd0; d = 64'd0; consumed = 1'b0;
        mul_live = mul_valid_i && (mul_rd_i != 5'd0);
        if (pipe_wb_en_i) begin
            en = 1'b1; a = pipe_rd_i; d = pipe_data_i;
            if (pipe_rd_i != 5'd0) begin
                foreach (mq[i]) begin
                    if (mq[i].rd == pipe_rd_i) mq[i].v = 1'b0;
                end
                if (mul_rd_i == pipe_rd_i) consumed = 1'b1;
            end
        end else if (mq.size() != 0) begin
            e = mq.pop_front();
            if (e.v) begin
                en = 1'b1; a = e.rd; d = e.data;
            end
        end else if (mul_live) begin
            en = 1'b1; a = mul_rd_i; d = mul_res_i; consumed = 1'b1;
        end
        if (mul_live && !consumed) begin
            if (mq.size() < DEPTH) mq.push_back('{v: 1'b1, rd: mul_rd_i, data: mul_res_i});
            else m_ovf = 1'b1;
        end
        exp_q.push_back({en, a, d});
    endfunction

    // ---------------- checkers ----------------
    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [4:0] addr, input logic [63:0] data);
        checks++;
        if (en) begin
            assert ({rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o} === {en, addr, data}) else begin
                errors++;
                $error("FAIL %s observed en=%0b rd=%0d data=%h expected en=1 rd=%0d data=%h",
                       tag, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, addr, data);
            end
        end else begin
            assert (rf_wr_en_o === 1'b0) else begin
                errors++;
                $error("FAIL %s observed en=%0b rd=%0d expected en=0", tag, rf_wr_en_o, rf_wr_addr_o);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic mv, input logic [4:0] mrd, input logic [63:0] mres,
                        input logic pe, input logic [4:0] prd, input logic [63:0] pd,
                        input logic [4:0] r1, input logic [4:0] r2);
        logic [69:0] exp;
        mul_valid_i  = mv;  mul_rd_i  = mrd; mul_res_i   = mres;
        pipe_wb_en_i = pe;  pipe_rd_i = prd; pipe_data_i = pd;
        rs1_addr_i   = r1;  rs2_addr_i = r2;
        #1;
        chk1("rs1_hazard", rs1_hazard_o, m_hazard(r1));
        chk1("rs2_hazard", rs2_hazard_o, m_hazard(r2));
        chk1("full", wbq_full_o, mq.size() == DEPTH);
        chk1("empty", wbq_empty_o, mq.size() == 0);
        chk1("overflow", overflow_o, m_ovf);
        model_step();
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        chk_wr("wr_port", exp[69], exp[68:64], exp[63:0]);
    endtask

    task automatic idle(input logic [4:0] r1);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, r1, 5'd0);
    endtask

    task automatic do_reset(input logic [4:0] r1, input logic [4:0] r2);
        reset = 1'b1;
        mul_valid_i = 1'b0; mul_rd_i = 5'd0; mul_res_i = 64'd0;
        pipe_wb_en_i = 1'b0; pipe_rd_i = 5'd0; pipe_data_i = 64'd0;
        rs1_addr_i = r1; rs2_addr_i = r2;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        #1;
        chk_wr("reset_wr", 1'b0, 5'd0, 64'd0);
        chk1("reset_addr_zero", rf_wr_addr_o == 5'd0 && rf_wr_data_o == 64'd0, 1'b1);
        chk1("reset_empty", wbq_empty_o, 1'b1);
        chk1("reset_full", wbq_full_o, 1'b0);
        chk1("reset_overflow", overflow_o, 1'b0);
        chk1("reset_rs1_hazard", rs1_hazard_o, 1'b0);
        chk1("reset_rs2_hazard", rs2_hazard_o, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        mul_valid_i = 1'b0; mul_rd_i = 5'd0; mul_res_i = 64'd0;
        pipe_wb_en_i = 1'b0; pipe_rd_i = 5'd0; pipe_data_i = 64'd0;
        rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
        m_ovf = 1'b0;

        do_reset(5'd0, 5'd0);

        // Bypass into an empty queue with the pipe idle
        step(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 5'd5, 5'd0);
        chk_wr("bypass_write", 1'b1, 5'd5, 64'h1234);
        chk1("bypass_stays_empty", wbq_empty_o, 1'b1);
        idle(5'd0);

        // Contention: three pipe writes, the mul result waits
        step(1'b1, 5'd7, 64'hAA, 1'b1, 5'd3, 64'h301, 5'd7, 5'd0);
        step(1'b0, 5'd0, 64'd0,  1'b1, 5'd3, 64'h302, 5'd7, 5'd0);
        step(1'b0, 5'd0, 64'd0,  1'b1, 5'd3, 64'h303, 5'd7, 5'd0);
        chk_wr("contention_pipe3", 1'b1, 5'd3, 64'h303);
        chk1("contention_hazard_held", rs1_hazard_o, 1'b1);
        idle(5'd7);
        chk_wr("contention_mul", 1'b1, 5'd7, 64'hAA);
        idle(5'd7);

        // Fill with the pipe busy, then overflow on the fifth result
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 5'(i), 64'h100 + 64'(i), 1'b1, 5'd20, 64'h2000 + 64'(i), 5'(i), 5'd0);
            if (i == 4) chk1("fill_full_after_4", wbq_full_o, 1'b1);
        end
        chk1("fill_overflow_after_5", overflow_o, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            idle(5'd5);
            chk_wr("drain_order", 1'b1, 5'(i), 64'h100 + 64'(i));
        end
        idle(5'd5);
        chk_wr("drain_no_rd5", 1'b0, 5'd0, 64'd0);

        // Push and pop in the same cycle at full
        do_reset(5'd0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd11 + 5'(i), 64'h1100 + 64'(i), 1'b1, 5'd20, 64'd0, 5'd0, 5'd0);
        end
        step(1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'd0, 5'd9, 5'd11);
        chk_wr("pushpop_head", 1'b1, 5'd11, 64'h1100);
        chk1("pushpop_still_full", wbq_full_o, 1'b1);
        chk1("pushpop_no_overflow", overflow_o, 1'b0);
        for (int i = 0; i < 4; i++) idle(5'd9);
        chk_wr("pushpop_tail", 1'b1, 5'd9, 64'h99);

        // WAW squash of a queued entry by a younger pipe write
        step(1'b1, 5'd10, 64'h55, 1'b1, 5'd21, 64'h2100, 5'd10, 5'd0);
        step(1'b0, 5'd0,  64'd0,  1'b1, 5'd10, 64'h66,   5'd10, 5'd0);
        chk_wr("waw_pipe", 1'b1, 5'd10, 64'h66);
        chk1("waw_no_hazard", rs1_hazard_o, 1'b0);
        idle(5'd10);
        chk_wr("waw_squashed_pop", 1'b0, 5'd0, 64'd0);
        chk1("waw_empty", wbq_empty_o, 1'b1);

        // Same-cycle same rd: mul dropped without overflow; x0 mul ignored
        step(1'b1, 5'd12, 64'h12, 1'b1, 5'd12, 64'h13, 5'd12, 5'd0);
        idle(5'd12);
        chk_wr("same_rd_dropped", 1'b0, 5'd0, 64'd0);
        chk1("same_rd_no_overflow", overflow_o, 1'b0);
        step(1'b1, 5'd0, 64'hF0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        chk_wr("x0_mul_ignored", 1'b0, 5'd0, 64'd0);

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd24 + 5'(i), 64'h2400 + 64'(i), 1'b1, 5'd20, 64'd0, 5'd0, 5'd0);
        end
        do_reset(5'd24, 5'd26);
        idle(5'd24);
        chk_wr("after_reset_no_write", 1'b0, 5'd0, 64'd0);

        // Random traffic with small register range to force collisions
        for (int n = 0; n < 800; n++) begin
            int pipe_pct;
            pipe_pct = ((n / 100) % 2 == 0) ? 85 : 35;
            if ($urandom_range(0, 149) == 0) begin
                do_reset(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end else begin
                step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                     1'($urandom_range(0, 99) < pipe_pct), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
